// File: rtl/finger_vote_pkg.sv
// Shared definitions for the finger-count majority voter: bin encoding,
// window state and counter width helper.
package finger_vote_pkg;

  localparam int unsigned MAX_FINGER  = 5;
  localparam int unsigned BIN_INVALID = MAX_FINGER + 1;
  localparam int unsigned NUM_BINS    = MAX_FINGER + 2;
  localparam int unsigned BIN_IDX_W   = $clog2(NUM_BINS);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } vote_state_e;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/finger_vote_history.sv
// DEPTH-entry shift FIFO of bin indices; a push while full implicitly pops
// the entry presented on oldest_o.
module finger_vote_history
  import finger_vote_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 flush_i,
  input  logic [BIN_IDX_W-1:0] bin_i,
  output logic [BIN_IDX_W-1:0] oldest_o
);

  logic [BIN_IDX_W-1:0] hist_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else if (push_i) begin
      hist_q[0] <= bin_i;
      for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign oldest_o = hist_q[DEPTH-1];

endmodule

// File: rtl/finger_vote.sv
// Sliding-window majority voter over per-frame finger counts; publishes a
// gesture only when one bin holds at least THRESH of the last DEPTH frames.
module finger_vote
  import finger_vote_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned THRESH = 6,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             begin_count,
  input  logic [3:0]       finger_number,
  output logic [3:0]       gesture_out,
  output logic             gesture_valid,
  output logic             gesture_change,
  output logic [CNT_W-1:0] fill_level
);

  vote_state_e          state_q, state_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]     bins_q [NUM_BINS];
  logic [CNT_W-1:0]     bins_d [NUM_BINS];
  logic                 eval_q, eval_d;
  logic [3:0]           out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 change_q, change_d;
  logic                 accept, full, win;
  logic [BIN_IDX_W-1:0] new_bin, old_bin, win_idx;

  finger_vote_history #(.DEPTH(DEPTH)) u_history (
    .clk     (vga_clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .flush_i (clear),
    .bin_i   (new_bin),
    .oldest_o(old_bin)
  );

  // Stage 1: window occupancy, state and histogram update.
  always_comb begin
    accept  = begin_count & ~clear;
    full    = (state_q == ST_FULL);
    new_bin = (finger_number <= 4'(MAX_FINGER)) ? BIN_IDX_W'(finger_number)
                                                : BIN_IDX_W'(BIN_INVALID);
    state_d = state_q;
    fill_d  = fill_q;
    eval_d  = accept;
    if (clear) begin
      state_d = ST_EMPTY;
      fill_d  = '0;
    end else if (accept && !full) begin
      fill_d  = fill_q + CNT_W'(1);
      state_d = (fill_d == CNT_W'(DEPTH)) ? ST_FULL : ST_FILL;
    end
    // new==old cancels to an unchanged count within one expression.
    for (int b = 0; b < NUM_BINS; b++) begin
      bins_d[b] = clear ? '0
                : bins_q[b]
                  + CNT_W'(accept && (new_bin == BIN_IDX_W'(b)))
                  - CNT_W'(accept && full && (old_bin == BIN_IDX_W'(b)));
    end
  end

  // Stage 2: majority scan of the histogram written on the previous edge.
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    for (int b = 0; b < NUM_BINS; b++) begin
      if (bins_q[b] >= CNT_W'(THRESH)) begin
        win     = 1'b1;
        win_idx = BIN_IDX_W'(b);
      end
    end
    out_d   = out_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (eval_q && win) begin
      if (win_idx == BIN_IDX_W'(BIN_INVALID)) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        out_d   = 4'(win_idx);
      end
    end
    change_d = ({valid_d, out_d} != {valid_q, out_q});
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      fill_q   <= '0;
      for (int b = 0; b < NUM_BINS; b++) bins_q[b] <= '0;
      eval_q   <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      for (int b = 0; b < NUM_BINS; b++) bins_q[b] <= bins_d[b];
      eval_q   <= eval_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      change_q <= change_d;
    end
  end

  assign gesture_out    = out_q;
  assign gesture_valid  = valid_q;
  assign gesture_change = change_q;
  assign fill_level     = fill_q;

endmodule

// File: tb/tb_finger_vote.sv
// Directed bench for finger_vote with DEPTH=8, THRESH=6.
module tb_finger_vote;

  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       begin_count;
  logic [3:0] finger_number;
  logic [3:0] gesture_out;
  logic       gesture_valid;
  logic       gesture_change;
  logic [3:0] fill_level;

  int n_cmp = 0;
  int n_err = 0;
  int chg_cnt = 0;
  int q[$];
  int mb[7];

  finger_vote #(.DEPTH(8), .THRESH(6)) dut (
    .vga_clk       (vga_clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .begin_count   (begin_count),
    .finger_number (finger_number),
    .gesture_out   (gesture_out),
    .gesture_valid (gesture_valid),
    .gesture_change(gesture_change),
    .fill_level    (fill_level)
  );

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) if (rst_n === 1'b1 && gesture_change === 1'b1) chg_cnt++;

  task automatic step(input logic bc, input logic [3:0] fn, input logic clr);
    begin_count   = bc;
    finger_number = fn;
    clear         = clr;
    @(posedge vga_clk);
    #1;
    begin_count = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int o, input int v, input int c);
    chk({tag, "_out"},    32'(gesture_out),    32'(o));
    chk({tag, "_valid"},  32'(gesture_valid),  32'(v));
    chk({tag, "_change"}, 32'(gesture_change), 32'(c));
  endtask

  initial begin
    int vec[14] = '{9, 12, 1, 1, 1, 1, 1, 1, 1, 1, 1, 5, 1, 0};
    rst_n = 1'b0; clear = 1'b0; begin_count = 1'b0; finger_number = '0;
    repeat (2) @(posedge vga_clk);
    #1;
    chk_out("reset", 0, 0, 0);
    chk("reset_fill", 32'(fill_level), 0);
    rst_n = 1'b1;

    // 1: six 3s reach the threshold; visible two cycles after the 6th strobe.
    repeat (6) step(1, 4'd3, 0);
    chk_out("t1_pre", 0, 0, 0);
    chk("t1_fill", 32'(fill_level), 6);
    step(0, 0, 0);
    chk_out("t1_win", 3, 1, 1);
    step(0, 0, 0);
    chk("t1_pulse_end", 32'(gesture_change), 0);
    chk("t1_chg_cnt", 32'(chg_cnt), 1);

    // 2: full window of 3s displaced by 5s.
    repeat (2) step(1, 4'd3, 0);
    chk("t2_fill8", 32'(fill_level), 8);
    repeat (5) step(1, 4'd5, 0);
    step(0, 0, 0);
    chk_out("t2_five5", 3, 1, 0);
    chk("t2_chg_hold", 32'(chg_cnt), 1);
    step(1, 4'd5, 0);
    step(0, 0, 0);
    chk_out("t2_switch", 5, 1, 1);
    chk("t2_bin3", 32'(dut.bins_q[3]), 2);
    chk("t2_bin5", 32'(dut.bins_q[5]), 6);
    step(0, 0, 0);
    chk("t2_chg_cnt", 32'(chg_cnt), 2);
    chk("t2_fill_cap", 32'(fill_level), 8);

    // 3: alternating 2/4 never reaches a majority; gesture 5 holds.
    for (int i = 0; i < 16; i++) step(1, (i % 2 == 1) ? 4'd4 : 4'd2, 0);
    repeat (2) step(0, 0, 0);
    chk_out("t3_hold", 5, 1, 0);
    chk("t3_bin2", 32'(dut.bins_q[2]), 4);
    chk("t3_bin4", 32'(dut.bins_q[4]), 4);
    chk("t3_chg_cnt", 32'(chg_cnt), 2);

    // 4: gesture 3, then invalid counts drop valid but hold the value.
    repeat (8) step(1, 4'd3, 0);
    repeat (2) step(0, 0, 0);
    chk_out("t4_three", 3, 1, 0);
    chk("t4_chg_a", 32'(chg_cnt), 3);
    repeat (8) step(1, 4'd9, 0);
    repeat (2) step(0, 0, 0);
    chk_out("t4_invalid", 3, 0, 0);
    chk("t4_chg_b", 32'(chg_cnt), 4);
    chk("t4_bin6", 32'(dut.bins_q[6]), 8);

    // 5: back-to-back strobes against a reference histogram.
    q.delete();
    foreach (mb[b]) mb[b] = 0;
    repeat (8) q.push_back(6);
    mb[6] = 8;
    foreach (vec[k]) begin
      int nb;
      nb = (vec[k] > 5) ? 6 : vec[k];
      if (q.size() == 8) mb[q.pop_front()]--;
      q.push_back(nb);
      mb[nb]++;
      step(1, 4'(vec[k]), 0);
      for (int b = 0; b < 7; b++) chk($sformatf("t5_s%0d_bin%0d", k, b), 32'(dut.bins_q[b]), 32'(mb[b]));
    end
    repeat (2) step(0, 0, 0);
    chk_out("t5_final", 1, 1, 0);
    chk("t5_fill", 32'(fill_level), 8);
    chk("t5_chg_cnt", 32'(chg_cnt), 5);

    // 6: clear with a strobe in FULL, then async reset mid-pipeline.
    step(1, 4'd3, 1);
    chk_out("t6_clear", 1, 0, 1);
    chk("t6_fill0", 32'(fill_level), 0);
    step(0, 0, 0);
    chk("t6_fill_after", 32'(fill_level), 0);
    chk("t6_dropped", 32'(dut.bins_q[3]), 0);
    chk("t6_pulse_end", 32'(gesture_change), 0);
    chk("t6_chg_cnt", 32'(chg_cnt), 6);
    repeat (6) step(1, 4'd2, 0);
    step(1, 4'd4, 0);
    chk_out("t6_pre_rst", 2, 1, 1);
    chk("t6_pre_fill", 32'(fill_level), 7);
    rst_n = 1'b0;
    #2;
    chk_out("t6_async_rst", 0, 0, 0);
    chk("t6_rst_fill", 32'(fill_level), 0);
    @(negedge vga_clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_out("t6_post_rst", 0, 0, 0);
    chk("t6_post_fill", 32'(fill_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
